// File: rtl/int_controller_if.sv
// Interrupt controller bus: device requests, mask load, CPU ack/eoi in; request and status out.
// Latency: pure wiring, no state.
// Backpressure: none; the CPU acknowledges through int_ack and signals completion through eoi.
interface int_controller_if #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_wr;
    logic [N_IRQ-1:0] mask_data;
    logic             int_ack;
    logic             eoi;
    logic             int_out;
    logic [IDX_W-1:0] int_vec;
    logic             in_service;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;

    // System side: drives requests and CPU strobes, observes the controller.
    modport master (
        output irq_in, mask_wr, mask_data, int_ack, eoi,
        input  int_out, int_vec, in_service, pending, mask
    );

    // Controller side.
    modport slave (
        input  irq_in, mask_wr, mask_data, int_ack, eoi,
        output int_out, int_vec, in_service, pending, mask
    );
endinterface

// File: rtl/int_controller.sv
// Interrupt request initiator for the MIPS core: pending/mask capture, fixed priority (lowest index wins).
// Latency: irq edge at clock k sets pending after k; int_out rises after k+1; reasserts 2 cycles after eoi.
// Backpressure: int_out held until int_ack; no nesting until eoi. Macro INTC_LEVEL_TRIG_EN selects level mode.
module int_controller #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    int_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             int_out_q, int_out_d;
    logic [IDX_W-1:0] int_vec_q, int_vec_d;
    logic             in_service_q, in_service_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;

    logic [N_IRQ-1:0] cand;
    logic [IDX_W-1:0] winner;

`ifndef INTC_LEVEL_TRIG_EN
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] clr_sel;
    logic             ack_clr;
`endif

    // Unmasked pending sources and the lowest-index winner among them.
    always_comb begin
        cand   = pending_q & ~mask_q;
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    // Request FSM: raise int_out, track winner while requesting, freeze it on ack.
    always_comb begin
        state_d      = state_q;
        int_out_d    = 1'b0;
        int_vec_d    = int_vec_q;
        in_service_d = in_service_q;
        unique case (state_q)
            IDLE: begin
                in_service_d = 1'b0;
                if (|cand) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                    int_vec_d = winner;
                end
            end
            REQ: begin
                // Ack has priority over a same-cycle eoi and over the source being masked off.
                if (bus.int_ack) begin
                    state_d      = SERVICE;
                    in_service_d = 1'b1;
                end else if (!(|cand)) begin
                    state_d = IDLE;
                end else begin
                    int_out_d = 1'b1;
                    int_vec_d = winner;
                end
            end
            SERVICE: begin
                in_service_d = 1'b1;
                if (bus.eoi) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                in_service_d = 1'b0;
            end
        endcase
    end

    // Pending and mask next-state: edge capture with set-over-clear, or level follow.
    always_comb begin
        mask_d = bus.mask_wr ? bus.mask_data : mask_q;
`ifdef INTC_LEVEL_TRIG_EN
        // Device owns its line, so pending simply mirrors it one cycle late.
        pending_d = bus.irq_in;
`else
        irq_prev_d = bus.irq_in;
        irq_edge   = bus.irq_in & ~irq_prev_q;
        // Ack clears the bit named by the registered vector, i.e. the pre-mask-write value.
        ack_clr    = (state_q == REQ) && bus.int_ack;
        clr_sel    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_sel[i] = ack_clr && (int_vec_q == IDX_W'(i));
        end
        pending_d  = (pending_q & ~clr_sel) | irq_edge;
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            int_out_q    <= 1'b0;
            int_vec_q    <= '0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            mask_q       <= '1;
`ifndef INTC_LEVEL_TRIG_EN
            irq_prev_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            int_out_q    <= int_out_d;
            int_vec_q    <= int_vec_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
`ifndef INTC_LEVEL_TRIG_EN
            irq_prev_q   <= irq_prev_d;
`endif
        end
    end

    assign bus.int_out    = int_out_q;
    assign bus.int_vec    = int_vec_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed stimulus pushes cycle-tagged expected outputs into a queue.
// A monitor sampling 1 time unit after each rising edge pops and compares entries due that cycle.
// Supports both the default edge build and the INTC_LEVEL_TRIG_EN build.
module tb_int_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        string      nm;
        int         cyc;
        logic       o;
        logic [2:0] v;
        logic       s;
        logic [7:0] p;
        logic [7:0] m;
    } exp_t;

    exp_t exp_q[$];

    int_controller_if #(.N_IRQ(8), .IDX_W(3)) bus ();

    int_controller #(.N_IRQ(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due on this cycle.
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.nm, e.cyc, cyc);
            end else if (bus.int_out !== e.o || bus.int_vec !== e.v || bus.in_service !== e.s ||
                         bus.pending !== e.p || bus.mask !== e.m) begin
                $display("FAIL %s @%0d: got out=%b vec=%0d svc=%b pend=%h mask=%h, want out=%b vec=%0d svc=%b pend=%h mask=%h",
                         e.nm, cyc, bus.int_out, bus.int_vec, bus.in_service, bus.pending, bus.mask,
                         e.o, e.v, e.s, e.p, e.m);
            end else begin
                n_pass++;
            end
        end
    end

    // Queue the expected outputs after the next rising edge, then advance to the next falling edge.
    task automatic step(input string nm, input logic o, input logic [2:0] v, input logic s,
                        input logic [7:0] p, input logic [7:0] m);
        exp_t e;
        e.nm  = nm;
        e.cyc = cyc + 1;
        e.o   = o;
        e.v   = v;
        e.s   = s;
        e.p   = p;
        e.m   = m;
        exp_q.push_back(e);
        @(negedge clk);
        bus.mask_wr = 1'b0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] m);
        bus.mask_wr   = 1'b1;
        bus.mask_data = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_in    = 8'h00;
        bus.mask_wr   = 1'b0;
        bus.mask_data = 8'h00;
        bus.int_ack   = 1'b0;
        bus.eoi       = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        step("reset", 0, 0, 0, 8'h00, 8'hFF);
        rst = 1'b0;

`ifdef INTC_LEVEL_TRIG_EN
        wr_mask(8'h00);             step("lv_mask",      0, 0, 0, 8'h00, 8'h00);
        bus.irq_in = 8'h04;         step("lv_pend",      0, 0, 0, 8'h04, 8'h00);
                                    step("lv_req",       1, 2, 0, 8'h04, 8'h00);
        bus.int_ack = 1'b1;         step("lv_ack_keep",  0, 2, 1, 8'h04, 8'h00);
        bus.eoi = 1'b1;             step("lv_eoi",       0, 2, 0, 8'h04, 8'h00);
                                    step("lv_rereq",     1, 2, 0, 8'h04, 8'h00);
        bus.irq_in = 8'h00;         step("lv_drop",      1, 2, 0, 8'h00, 8'h00);
                                    step("lv_idle",      0, 2, 0, 8'h00, 8'h00);
`else
        // Single pulse on source 3 through ack and eoi.
        wr_mask(8'h00);             step("t1_mask",      0, 0, 0, 8'h00, 8'h00);
        bus.irq_in = 8'h08;         step("t1_pend",      0, 0, 0, 8'h08, 8'h00);
        bus.irq_in = 8'h00;         step("t1_req",       1, 3, 0, 8'h08, 8'h00);
        bus.int_ack = 1'b1;         step("t1_ack",       0, 3, 1, 8'h00, 8'h00);
                                    step("t1_svc_hold",  0, 3, 1, 8'h00, 8'h00);
        bus.eoi = 1'b1;             step("t1_eoi",       0, 3, 0, 8'h00, 8'h00);

        // Higher-priority arrival while requesting; remaining source re-requests after eoi.
        bus.irq_in = 8'h20;         step("t2_pend5",     0, 3, 0, 8'h20, 8'h00);
        bus.irq_in = 8'h22;         step("t2_req5",      1, 5, 0, 8'h22, 8'h00);
                                    step("t2_req1",      1, 1, 0, 8'h22, 8'h00);
        bus.int_ack = 1'b1;         step("t2_ack1",      0, 1, 1, 8'h20, 8'h00);
        bus.eoi = 1'b1;             step("t2_eoi",       0, 1, 0, 8'h20, 8'h00);
                                    step("t2_rereq5",    1, 5, 0, 8'h20, 8'h00);
        bus.int_ack = 1'b1; bus.irq_in = 8'h00;
                                    step("t2_ack5",      0, 5, 1, 8'h00, 8'h00);
        bus.eoi = 1'b1;             step("t2_eoi5",      0, 5, 0, 8'h00, 8'h00);

        // Masked source stays pending; unmask raises, remask withdraws.
        wr_mask(8'hFF);             step("t3_maskall",   0, 5, 0, 8'h00, 8'hFF);
        bus.irq_in = 8'h01;         step("t3_pend_msk",  0, 5, 0, 8'h01, 8'hFF);
                                    step("t3_no_req",    0, 5, 0, 8'h01, 8'hFF);
        wr_mask(8'hFE);             step("t3_unmask",    0, 5, 0, 8'h01, 8'hFE);
                                    step("t3_req0",      1, 0, 0, 8'h01, 8'hFE);
        wr_mask(8'hFF);             step("t3_remask",    1, 0, 0, 8'h01, 8'hFF);
                                    step("t3_withdraw",  0, 0, 0, 8'h01, 8'hFF);
        bus.irq_in = 8'h00; wr_mask(8'h00);
                                    step("t3_open",      0, 0, 0, 8'h01, 8'h00);
                                    step("t3_req0b",     1, 0, 0, 8'h01, 8'h00);
        bus.int_ack = 1'b1;         step("t3_ack0",      0, 0, 1, 8'h00, 8'h00);
        bus.eoi = 1'b1;             step("t3_eoi",       0, 0, 0, 8'h00, 8'h00);

        // No nesting during service; stray ack ignored.
        bus.irq_in = 8'h04;         step("t4_pend2",     0, 0, 0, 8'h04, 8'h00);
        bus.irq_in = 8'h00;         step("t4_req2",      1, 2, 0, 8'h04, 8'h00);
        bus.int_ack = 1'b1;         step("t4_ack2",      0, 2, 1, 8'h00, 8'h00);
        bus.irq_in = 8'h01;         step("t4_pend0_svc", 0, 2, 1, 8'h01, 8'h00);
        bus.irq_in = 8'h00; bus.int_ack = 1'b1;
                                    step("t4_ack_ign",   0, 2, 1, 8'h01, 8'h00);
                                    step("t4_svc_hold",  0, 2, 1, 8'h01, 8'h00);
        bus.eoi = 1'b1;             step("t4_eoi",       0, 2, 0, 8'h01, 8'h00);
                                    step("t4_req0",      1, 0, 0, 8'h01, 8'h00);
        bus.int_ack = 1'b1;         step("t4_ack0",      0, 0, 1, 8'h00, 8'h00);
        bus.eoi = 1'b1;             step("t4_eoi0",      0, 0, 0, 8'h00, 8'h00);

        // New edge on the acked source wins over the clear; reset mid-service.
        bus.irq_in = 8'h10;         step("t5_pend4",     0, 0, 0, 8'h10, 8'h00);
        bus.irq_in = 8'h00;         step("t5_req4",      1, 4, 0, 8'h10, 8'h00);
        bus.irq_in = 8'h10; bus.int_ack = 1'b1;
                                    step("t5_set_wins",  0, 4, 1, 8'h10, 8'h00);
        bus.irq_in = 8'h00; rst = 1'b1;
                                    step("t5_rst_svc",   0, 0, 0, 8'h00, 8'hFF);
        rst = 1'b0;                 step("t5_post_rst",  0, 0, 0, 8'h00, 8'hFF);

        // Line high across reset release counts as an edge; ack+eoi together takes only the ack.
        rst = 1'b1; bus.irq_in = 8'h02;
                                    step("t5_rst_hi",    0, 0, 0, 8'h00, 8'hFF);
        rst = 1'b0;                 step("t5_first_edge",0, 0, 0, 8'h02, 8'hFF);
        wr_mask(8'h00);             step("t5_open",      0, 0, 0, 8'h02, 8'h00);
                                    step("t5_req1",      1, 1, 0, 8'h02, 8'h00);
        bus.int_ack = 1'b1; bus.eoi = 1'b1;
                                    step("t5_ack_eoi",   0, 1, 1, 8'h00, 8'h00);
                                    step("t5_svc_hold",  0, 1, 1, 8'h00, 8'h00);
        bus.eoi = 1'b1;             step("t5_eoi",       0, 1, 0, 8'h00, 8'h00);
`endif

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never compared", e.nm, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
